// File: rtl/pio_irq_pkg.sv
// Shared register offsets and edge-polarity encodings for the edge-capturing input PIO.
package pio_irq_pkg;

   localparam logic [2:0] REG_DATA         = 3'd0;
   localparam logic [2:0] REG_EDGE_POL     = 3'd1;
   localparam logic [2:0] REG_IRQ_MASK     = 3'd2;
   localparam logic [2:0] REG_EDGE_CAPTURE = 3'd3;
   localparam logic [2:0] REG_EDGE_ANY     = 3'd4;
   localparam logic [2:0] REG_EVENT_COUNT  = 3'd5;

   localparam logic POL_RISE = 1'b0;
   localparam logic POL_FALL = 1'b1;

endpackage

// File: rtl/pio_bit_filter.sv
// One input bit: synchroniser chain followed by an optional persistence filter.
module pio_bit_filter #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic in_bit,
   output logic f
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   if (FILTER_CYCLES == 0) begin : g_bypass
      assign f = s;
   end else begin : g_filter
      localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

      logic [CntW-1:0] cnt_q;
      logic            f_q;

      // f only follows s once s has disagreed for FILTER_CYCLES consecutive cycles.
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
            f_q   <= 1'b0;
         end else if (s == f_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
            f_q   <= s;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end

      assign f = f_q;
   end

endmodule

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO with per-bit edge detection, W1C capture, maskable irq and event counter.
module pio_edge_irq_in
   import pio_irq_pkg::*;
#(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 0,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0]       f;
   logic [WIDTH-1:0]       f_d_q;
   logic [WIDTH-1:0]       pol_q;
   logic [WIDTH-1:0]       mask_q;
   logic [WIDTH-1:0]       any_q;
   logic [WIDTH-1:0]       cap_q;
   logic [WIDTH-1:0]       cap_d;
   logic [COUNT_WIDTH-1:0] cnt_q;
   logic [COUNT_WIDTH-1:0] cnt_d;
   logic [31:0]            readdata_q;
   logic [31:0]            rd_mux;
   logic [WIDTH-1:0]       rise;
   logic [WIDTH-1:0]       fall;
   logic [WIDTH-1:0]       det;
   logic [WIDTH-1:0]       wdata;
   logic                   wr;
   logic                   unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_bit_filter #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filter (
         .clk   (clk),
         .reset (reset),
         .in_bit(in_port[i]),
         .f     (f[i])
      );
   end

   assign wr           = chipselect & ~write_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;

   assign rise = f & ~f_d_q;
   assign fall = ~f & f_d_q;
   assign det  = (any_q & (rise | fall)) |
                 (~any_q & ((pol_q & fall) | (~pol_q & rise)));

   always_comb begin
      cap_d = cap_q;
      if (wr && (address == REG_EDGE_CAPTURE)) begin
         cap_d = cap_q & ~wdata;
      end
      // A fresh edge outranks a simultaneous clear.
      cap_d = cap_d | det;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wr && (address == REG_EVENT_COUNT)) begin
         cnt_d = (|det) ? COUNT_WIDTH'(1) : '0;
      end else if ((|det) && !(&cnt_q)) begin
         cnt_d = cnt_q + COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         REG_DATA:         rd_mux[WIDTH-1:0]       = f;
         REG_EDGE_POL:     rd_mux[WIDTH-1:0]       = pol_q;
         REG_IRQ_MASK:     rd_mux[WIDTH-1:0]       = mask_q;
         REG_EDGE_CAPTURE: rd_mux[WIDTH-1:0]       = cap_q;
         REG_EDGE_ANY:     rd_mux[WIDTH-1:0]       = any_q;
         REG_EVENT_COUNT:  rd_mux[COUNT_WIDTH-1:0] = cnt_q;
         default:          rd_mux                  = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         f_d_q      <= '0;
         pol_q      <= '0;
         mask_q     <= '0;
         any_q      <= '0;
         cap_q      <= '0;
         cnt_q      <= '0;
         readdata_q <= '0;
      end else begin
         f_d_q      <= f;
         cap_q      <= cap_d;
         cnt_q      <= cnt_d;
         readdata_q <= rd_mux;
         if (wr && (address == REG_EDGE_POL)) pol_q  <= wdata;
         if (wr && (address == REG_IRQ_MASK)) mask_q <= wdata;
         if (wr && (address == REG_EDGE_ANY)) any_q  <= wdata;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(cap_q & mask_q);

endmodule
